// File: rtl/inst_dec_stage.sv
// rtl/inst_dec_stage.sv - registered RV32I/RV64I decode stage with optional skid buffer
module inst_dec_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Decoded view of the incoming instruction
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;

  // Output register
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [2:0]      out_fmt_q, out_fmt_d;
  logic            out_ill_q, out_ill_d;

  // Skid entry (only ever filled when SKID_EN=1)
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_inst_q, skid_inst_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [2:0]      skid_fmt_q, skid_fmt_d;
  logic            skid_ill_q, skid_ill_d;

  // Registered ready; also low during reset and until the first edge after release
  logic            in_ready_q, in_ready_d;

  logic            accept;
  logic            out_free;

  // Classify format and build the 32-bit immediate; widened by sign extension afterwards
  always_comb begin
    dec_fmt   = FMT_ILL;
    dec_ill   = 1'b1;
    dec_imm32 = 32'd0;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        7'b0110011: begin
          dec_fmt = FMT_R;
          dec_ill = 1'b0;
        end
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
          dec_fmt   = FMT_I;
          dec_ill   = 1'b0;
          dec_imm32 = {{20{inst[31]}}, inst[31:20]};
        end
        7'b0100011: begin
          dec_fmt   = FMT_S;
          dec_ill   = 1'b0;
          dec_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end
        7'b1100011: begin
          dec_fmt   = FMT_B;
          dec_ill   = 1'b0;
          dec_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec_fmt   = FMT_U;
          dec_ill   = 1'b0;
          dec_imm32 = {inst[31:12], 12'd0};
        end
        7'b1101111: begin
          dec_fmt   = FMT_J;
          dec_ill   = 1'b0;
          dec_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        default: begin
          dec_fmt   = FMT_ILL;
          dec_ill   = 1'b1;
          dec_imm32 = 32'd0;
        end
      endcase
    end
    dec_imm = XLEN'($signed(dec_imm32));
  end

  // With the skid buffer ready is a pure flop; without it ready follows the output slot
  assign in_ready = SKID_EN ? in_ready_q : (in_ready_q && (!out_valid_q || out_ready));
  assign accept   = in_valid && in_ready && !flush;
  assign out_free = !out_valid_q || out_ready;

  // Next-state: flush wins, then drain skid into output, then take new instruction
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (SKID_EN && skid_valid_q) begin
        out_valid_d = 1'b1;
        out_pc_d    = skid_pc_q;
        out_inst_d  = skid_inst_q;
        out_imm_d   = skid_imm_q;
        out_fmt_d   = skid_fmt_q;
        out_ill_d   = skid_ill_q;
        if (accept) begin
          skid_valid_d = 1'b1;
          skid_pc_d    = pc;
          skid_inst_d  = inst;
          skid_imm_d   = dec_imm;
          skid_fmt_d   = dec_fmt;
          skid_ill_d   = dec_ill;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_pc_d    = pc;
        out_inst_d  = inst;
        out_imm_d   = dec_imm;
        out_fmt_d   = dec_fmt;
        out_ill_d   = dec_ill;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (SKID_EN && accept) begin
      // Output stalled: park the new bundle behind it
      skid_valid_d = 1'b1;
      skid_pc_d    = pc;
      skid_inst_d  = inst;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_ill_d   = dec_ill;
    end

    in_ready_d = SKID_EN ? !skid_valid_d : 1'b1;
  end

  // State registers; reset clears valids and every visible data field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_inst_q   <= '0;
      out_imm_q    <= '0;
      out_fmt_q    <= 3'd0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= 3'd0;
      skid_ill_q   <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_out    = out_pc_q;
  assign opcode    = out_inst_q[6:0];
  assign rd        = out_inst_q[11:7];
  assign funct3    = out_inst_q[14:12];
  assign rs1       = out_inst_q[19:15];
  assign rs2       = out_inst_q[24:20];
  assign funct7    = out_inst_q[31:25];
  assign imm       = out_imm_q;
  assign fmt       = out_fmt_q;
  assign illegal   = out_ill_q;

endmodule

// File: tb/tb_inst_dec_stage.sv
// tb/tb_inst_dec_stage.sv - randomized self-checking bench for inst_dec_stage
module tb_inst_dec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [63:0] pc;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_pc_out, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_funct3, a_fmt;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [63:0] b_pc_out, b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3, b_fmt;

  always #5 clk = ~clk;

  inst_dec_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .inst(inst), .pc(pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .pc_out(a_pc_out), .opcode(a_opcode), .rd(a_rd), .funct3(a_funct3), .rs1(a_rs1),
    .rs2(a_rs2), .funct7(a_funct7), .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal)
  );

  inst_dec_stage #(.XLEN(64), .SKID_EN(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .inst(inst), .pc(pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .pc_out(b_pc_out), .opcode(b_opcode), .rd(b_rd), .funct3(b_funct3), .rs1(b_rs1),
    .rs2(b_rs2), .funct7(b_funct7), .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  bit    init;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Immediate and format straight from the ISA bit layout, as signed arithmetic
  task automatic ref_dec(input logic [31:0] i, output logic [63:0] imm_e, output int fmt_e);
    longint lo;
    longint v;
    v = 0;
    fmt_e = 7;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'h33: fmt_e = 0;
        7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
          fmt_e = 1; lo = i[30:20]; v = lo - (i[31] ? 64'sd2048 : 64'sd0);
        end
        7'h23: begin
          fmt_e = 2; lo = {i[30:25], i[11:7]}; v = lo - (i[31] ? 64'sd2048 : 64'sd0);
        end
        7'h63: begin
          fmt_e = 3; lo = {i[7], i[30:25], i[11:8]}; v = lo * 2 - (i[31] ? 64'sd4096 : 64'sd0);
        end
        7'h37, 7'h17: begin
          fmt_e = 4; lo = i[30:12]; v = lo * 4096 - (i[31] ? 64'sd2147483648 : 64'sd0);
        end
        7'h6F: begin
          fmt_e = 5; lo = {i[19:12], i[20], i[30:21]}; v = lo * 2 - (i[31] ? 64'sd1048576 : 64'sd0);
        end
        default: fmt_e = 7;
      endcase
    end
    imm_e = 64'(v);
  endtask

  // Compare one DUT against its FIFO model: k=0 is 32-bit/skid (depth 2), k=1 is 64-bit/no skid (depth 1)
  task automatic check_dut(input int k);
    logic        ov, ir, il;
    logic [63:0] pco, immo, imm_e, msk;
    logic [31:0] raw;
    logic [2:0]  fo;
    int          cnt, fmt_e;
    bit          exp_ir;
    item_t       it;
    if (k == 0) begin
      ov = a_out_valid; ir = a_in_ready; pco = {32'd0, a_pc_out}; immo = {32'd0, a_imm};
      raw = {a_funct7, a_rs2, a_rs1, a_funct3, a_rd, a_opcode}; fo = a_fmt; il = a_illegal;
      cnt = q0.size(); exp_ir = init && (cnt < 2); msk = 64'h0000_0000_FFFF_FFFF;
    end else begin
      ov = b_out_valid; ir = b_in_ready; pco = b_pc_out; immo = b_imm;
      raw = {b_funct7, b_rs2, b_rs1, b_funct3, b_rd, b_opcode}; fo = b_fmt; il = b_illegal;
      cnt = q1.size(); exp_ir = init && (cnt == 0 || out_ready); msk = '1;
    end
    check($sformatf("d%0d.out_valid", k), {63'd0, ov}, {63'd0, cnt > 0});
    check($sformatf("d%0d.in_ready", k), {63'd0, ir}, {63'd0, exp_ir});
    if (cnt > 0) begin
      it = (k == 0) ? q0[0] : q1[0];
      ref_dec(it.inst, imm_e, fmt_e);
      check($sformatf("d%0d.pc_out", k), pco, it.pc & msk);
      check($sformatf("d%0d.fields", k), {32'd0, raw}, {32'd0, it.inst});
      check($sformatf("d%0d.imm", k), immo, imm_e & msk);
      check($sformatf("d%0d.fmt", k), {61'd0, fo}, 64'(fmt_e));
      check($sformatf("d%0d.illegal", k), {63'd0, il}, {63'd0, fmt_e == 7});
    end
  endtask

  task automatic cycle(input bit iv, input logic [31:0] ins, input logic [63:0] p,
                       input bit ordy, input bit fl);
    int  c0, c1;
    bit  ir0, ir1;
    item_t it;
    @(negedge clk);
    in_valid = iv; inst = ins; pc = p; out_ready = ordy; flush = fl;
    #1;
    check_dut(0);
    check_dut(1);
    c0 = q0.size(); c1 = q1.size();
    ir0 = init && (c0 < 2);
    ir1 = init && (c1 == 0 || ordy);
    it.pc = p; it.inst = ins;
    if (c0 > 0 && ordy) void'(q0.pop_front());
    if (c1 > 0 && ordy) void'(q1.pop_front());
    if (fl) begin
      q0.delete(); q1.delete();
    end else begin
      if (iv && ir0) q0.push_back(it);
      if (iv && ir1) q1.push_back(it);
    end
    init = 1'b1;
  endtask

  // Async reset asserted between clock edges; outputs must clear with no edge
  task automatic do_reset();
    #1 rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    #1;
    check("rst.a_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst.b_out_valid", {63'd0, b_out_valid}, 64'd0);
    check("rst.a_in_ready", {63'd0, a_in_ready}, 64'd0);
    check("rst.b_in_ready", {63'd0, b_in_ready}, 64'd0);
    check("rst.a_data", {a_pc_out, a_imm}, 64'd0);
    check("rst.b_imm", b_imm, 64'd0);
    check("rst.a_fields", {32'd0, a_funct7, a_rs2, a_rs1, a_funct3, a_rd, a_opcode}, 64'd0);
    check("rst.fmt_ill", {58'd0, a_fmt, b_fmt}, 64'd0);
    q0.delete(); q1.delete();
    init = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel.a_in_ready", {63'd0, a_in_ready}, 64'd0);
    check("rel.b_in_ready", {63'd0, b_in_ready}, 64'd0);
    init = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    r = $urandom;
    if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 10)];
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = '0; pc = '0; init = 1'b0;
    do_reset();

    // addi x1,x2,-1
    cycle(1, 32'hFFF10093, 64'h100, 1, 0);
    cycle(0, 32'h0, 64'h0, 1, 0);
    check("addi.valid", {63'd0, a_out_valid}, 64'd1);
    check("addi.rd_rs1_f3", {51'd0, a_rd, a_rs1, a_funct3}, {51'd0, 5'd1, 5'd2, 3'd0});
    check("addi.fmt", {61'd0, a_fmt}, 64'd1);
    check("addi.imm", {32'd0, a_imm}, 64'hFFFF_FFFF);
    check("addi.pc", {32'd0, a_pc_out}, 64'h100);
    check("addi.illegal", {63'd0, a_illegal}, 64'd0);

    // sw, beq, lui back to back
    cycle(1, 32'h00112623, 64'h200, 1, 0);
    cycle(1, 32'hFE000EE3, 64'h204, 1, 0);
    check("sw.fmt_imm_rs2", {a_fmt, a_imm, a_rs2}, {3'd2, 32'd12, 5'd1});
    cycle(1, 32'h123452B7, 64'h208, 1, 0);
    check("beq.fmt_imm", {a_fmt, a_imm}, {3'd3, 32'hFFFF_FFFC});
    cycle(0, 32'h0, 64'h0, 1, 0);
    check("lui.fmt_imm_rd", {a_fmt, a_imm, a_rd}, {3'd4, 32'h1234_5000, 5'd5});

    // backpressure: three offers into a stalled output
    cycle(1, 32'h00100093, 64'h300, 0, 0);
    cycle(1, 32'h00200113, 64'h304, 0, 0);
    cycle(1, 32'h00300193, 64'h308, 0, 0);
    check("bp.in_ready_3rd", {63'd0, a_in_ready}, 64'd0);
    cycle(1, 32'h00300193, 64'h308, 0, 0);
    check("bp.stable_pc", {32'd0, a_pc_out}, 64'h300);
    cycle(1, 32'h00300193, 64'h308, 1, 0);
    cycle(1, 32'h00300193, 64'h308, 1, 0);
    cycle(0, 32'h0, 64'h0, 1, 0);
    cycle(0, 32'h0, 64'h0, 1, 0);

    // illegal encodings
    cycle(1, 32'h00000000, 64'h400, 1, 0);
    cycle(1, 32'h0000007F, 64'h404, 1, 0);
    check("ill0.ill_fmt_imm", {a_illegal, a_fmt, a_imm}, {1'b1, 3'd7, 32'd0});
    cycle(0, 32'h0, 64'h0, 1, 0);
    check("ill7f.ill_fmt_imm", {a_illegal, a_fmt, a_imm}, {1'b1, 3'd7, 32'd0});

    // flush with output and skid full, new instruction offered
    cycle(1, 32'h00500293, 64'h500, 0, 0);
    cycle(1, 32'h00600313, 64'h504, 0, 0);
    cycle(1, 32'h00700393, 64'hDEAD, 0, 1);
    cycle(0, 32'h0, 64'h0, 1, 0);
    check("flush.out_valid", {63'd0, a_out_valid}, 64'd0);
    check("flush.in_ready", {63'd0, a_in_ready}, 64'd1);
    cycle(0, 32'h0, 64'h0, 1, 0);

    // reset while stalled, then lui with bit 31 set
    cycle(1, 32'h00800413, 64'h600, 0, 0);
    cycle(1, 32'h00900493, 64'h604, 0, 0);
    do_reset();
    cycle(1, 32'h800000B7, 64'h700, 1, 0);
    cycle(0, 32'h0, 64'h0, 1, 0);
    check("lui64.imm", b_imm, 64'hFFFF_FFFF_8000_0000);
    check("lui32.imm", {32'd0, a_imm}, 64'h8000_0000);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if (n % 997 == 500) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) < 7, rand_inst(), {$urandom, $urandom},
              $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 4);
      end
    end
    for (int n = 0; n < 4; n++) cycle(0, 32'h0, 64'h0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_dec_stage.md
Name: inst_dec_stage

Overview:
- Registered, parametrised RISC-V RV32I/RV64I decode stage.
- Sits between fetch and register-read/execute.
- Splits the instruction into fields, generates the sign-extended immediate, classifies the format, and flags illegal encodings.
- Pipeline register with valid/ready handshake, optional skid buffer and flush; successor to the combinational field decoder.

Parameters:
- XLEN, 32, datapath width for pc and imm (32 or 64).
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with pass-through ready.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  discard all held and incoming instructions.
- in_valid  input  1  fetch presents inst/pc.
- in_ready  output  1  stage can accept.
- inst  input  32  raw instruction.
- pc  input  XLEN  address of inst.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts.
- pc_out  output  XLEN  pc of bundle.
- opcode  output  7  inst[6:0].
- rd  output  5  inst[11:7].
- funct3  output  3  inst[14:12].
- rs1  output  5  inst[19:15].
- rs2  output  5  inst[24:20].
- funct7  output  7  inst[31:25].
- imm  output  XLEN  sign-extended immediate.
- fmt  output  3  0=R 1=I 2=S 3=B 4=U 5=J 7=illegal.
- illegal  output  1  unsupported encoding.

Behaviour:
- Reset (async, rst_n=0): out_valid=0 and skid_valid=0. All data outputs (pc_out, opcode, rd, funct3, rs1, rs2, funct7, imm) go to 0. fmt=0, illegal=0, in_ready=0 while rst_n=0 and 1 from the first clk edge after release. Reset mid-transfer drops the held instruction.
- Decode is combinational on the incoming inst. The result is captured when in_valid&&in_ready. Latency is exactly 1 cycle from acceptance to out_valid.
- Opcode map:
  - 0110011 -> R
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - Anything else, or inst[1:0]!=2'b11 -> fmt=7, illegal=1, imm=0.
- Immediates, all sign-extended from inst[31] to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - U: {inst[31:12],12'b0}, sign-extended above bit 31 when XLEN=64.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - R: imm=0.
- Field outputs (rd, rs1, etc.) always reflect the raw bits, regardless of fmt.
- Output register updates only when !out_valid || out_ready. Otherwise the bundle and out_valid hold stable; no change while stalled.
- SKID_EN=1:
  - in_ready = !skid_valid, a registered signal with no combinational path from out_ready.
  - If an accept happens while the output is stalled, the decoded bundle goes to the skid entry.
  - When the output frees, the skid entry moves to output first (FIFO order), then skid_valid clears.
  - Accept and drain in the same cycle: output takes skid, skid takes new. The skid can only be full if the output is full.
- SKID_EN=0: in_ready = !out_valid || out_ready (combinational).
- Flush:
  - Next edge: out_valid=0, skid_valid=0.
  - Any same-cycle accept is discarded; flush takes priority.
  - in_ready is 1 in the cycle after flush.
  - A downstream transfer in the flush cycle still counts as completed.
- Bundles are never duplicated or reordered. Every accepted, unflushed instruction appears on the output exactly once.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), pc=0x100, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, funct3=0, fmt=1, imm=0xFFFFFFFF, pc_out=0x100, illegal=0.
- Back-to-back sw x1,12(x2) (0x00112623), beq x0,x0,-4 (0xFE000EE3), lui x5,0x12345 (0x123452B7):
  - sw -> fmt=2, imm=12, rs2=1.
  - beq -> fmt=3, imm=0xFFFFFFFC.
  - lui -> fmt=4, imm=0x12345000, rd=5.
  - One per cycle, in order.
- Backpressure, SKID_EN=1: hold out_ready=0 and offer 3 instructions -> 2 accepted, in_ready=0 on 3rd. Outputs stable while stalled. Release -> the 2 accepted emerge in order, then the 3rd is accepted.
- Illegal: inst=0x00000000 and 0x0000007F -> illegal=1, fmt=7, imm=0, still handshaken normally.
- Flush with output+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed instruction never appears.
- Assert rst_n=0 mid-stall -> out_valid drops immediately (async, no clk edge). After release, first accept decodes normally. Repeat with SKID_EN=0 and XLEN=64 (lui 0x800000B7 -> imm=0xFFFFFFFF80000000).
